// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - shared types for the Panda RV32 load/store path
package panda_pkg;

    typedef enum logic [1:0] {
        LSU_WIDTH_BYTE = 2'd0,
        LSU_WIDTH_HALF = 2'd1,
        LSU_WIDTH_WORD = 2'd2
    } lsu_width_e;

endpackage

// File: rtl/panda_sc_lsu_load_extend.sv
// rtl/panda_sc_lsu_load_extend.sv - load lane select and sign/zero extension
module panda_sc_lsu_load_extend
    import panda_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  lsu_width_e  width_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Unencoded width 2'b11 falls into the word case
    always_comb begin
        case (width_i)
            LSU_WIDTH_BYTE: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            LSU_WIDTH_HALF: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default:        data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/sc_load_store_unit.sv
// rtl/sc_load_store_unit.sv - single-cycle LSU; PANDA_LSU_MISALIGN_CHECK_EN enables
// misalignment detection, store suppression and the sticky error record.
module sc_load_store_unit
    import panda_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        store_i,
    input  logic        load_i,
    input  logic        load_unsigned_i,
    input  lsu_width_e  width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] data_wdata_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_we_o,
    input  logic        err_clear_i,
    output logic        misaligned_o,
    output logic        err_valid_o,
    output logic [31:0] err_addr_o
);

    logic [1:0] off;
    logic [3:0] lane_we;

    assign off         = addr_i[1:0];
    assign data_addr_o = {addr_i[31:2], 2'b00};

    always_comb begin
        case (width_i)
            LSU_WIDTH_BYTE: begin
                data_wdata_o = {4{store_data_i[7:0]}};
                lane_we      = 4'b0001 << off;
            end
            LSU_WIDTH_HALF: begin
                data_wdata_o = {2{store_data_i[15:0]}};
                lane_we      = 4'b0011 << {off[1], 1'b0};
            end
            default: begin
                data_wdata_o = store_data_i;
                lane_we      = 4'b1111;
            end
        endcase
    end

    panda_sc_lsu_load_extend u_load_extend (
        .rdata_i    (data_rdata_i),
        .off_i      (off),
        .width_i    (width_i),
        .unsigned_i (load_unsigned_i),
        .data_o     (load_data_o)
    );

`ifdef PANDA_LSU_MISALIGN_CHECK_EN
    logic        is_word;
    logic        misaligned;
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;

    assign is_word    = (width_i != LSU_WIDTH_BYTE) && (width_i != LSU_WIDTH_HALF);
    assign misaligned = (load_i | store_i) &
                        (((width_i == LSU_WIDTH_HALF) & addr_i[0]) | (is_word & (off != 2'b00)));

    assign misaligned_o = misaligned;
    assign data_we_o    = (store_i && !misaligned) ? lane_we : 4'b0000;

    // Only the first misaligned access is recorded; clear wins over a new one
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_clear_i) begin
            err_valid_d = 1'b0;
        end else if (misaligned && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'h0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
`else
    logic unused_misalign_inputs;

    assign unused_misalign_inputs = ^{load_i, err_clear_i, clk_i, rst_ni};
    assign data_we_o    = store_i ? lane_we : 4'b0000;
    assign misaligned_o = 1'b0;
    assign err_valid_o  = 1'b0;
    assign err_addr_o   = 32'h0;
`endif

endmodule

// File: tb/tb_sc_load_store_unit.sv
// tb/tb_sc_load_store_unit.sv - directed self-checking bench for sc_load_store_unit
module tb_sc_load_store_unit;
    import panda_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        store, load, load_unsigned, err_clear;
    lsu_width_e  width;
    logic [31:0] addr, store_data, rdata;
    logic [31:0] load_data, wdata, daddr, err_addr;
    logic [3:0]  we;
    logic        misaligned, err_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sc_load_store_unit dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .store_i         (store),
        .load_i          (load),
        .load_unsigned_i (load_unsigned),
        .width_i         (width),
        .addr_i          (addr),
        .store_data_i    (store_data),
        .load_data_o     (load_data),
        .data_rdata_i    (rdata),
        .data_wdata_o    (wdata),
        .data_addr_o     (daddr),
        .data_we_o       (we),
        .err_clear_i     (err_clear),
        .misaligned_o    (misaligned),
        .err_valid_o     (err_valid),
        .err_addr_o      (err_addr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ld, input logic uns,
                         input lsu_width_e w, input logic [31:0] a);
        @(negedge clk);
        store         = st;
        load          = ld;
        load_unsigned = uns;
        width         = w;
        addr          = a;
        #1;
    endtask

    logic [31:0] byte_s [4] = '{32'hFFFFFFEF, 32'h00000067, 32'hFFFFFFAB, 32'hFFFFFF89};
    logic [31:0] byte_u [4] = '{32'h000000EF, 32'h00000067, 32'h000000AB, 32'h00000089};

    initial begin
        rst_n         = 1'b0;
        store         = 1'b0;
        load          = 1'b0;
        load_unsigned = 1'b0;
        err_clear     = 1'b0;
        width         = LSU_WIDTH_WORD;
        addr          = 32'h0;
        store_data    = 32'h12345678;
        rdata         = 32'h89AB67EF;
        #2;
        check("rst_err_valid", {31'h0, err_valid}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, LSU_WIDTH_BYTE, 32'(i));
            check($sformatf("lb_%0d", i), load_data, byte_s[i]);
            drive(1'b0, 1'b1, 1'b1, LSU_WIDTH_BYTE, 32'(i));
            check($sformatf("lbu_%0d", i), load_data, byte_u[i]);
        end

        drive(1'b0, 1'b1, 1'b0, LSU_WIDTH_HALF, 32'h0);
        check("lh_0", load_data, 32'h000067EF);
        drive(1'b0, 1'b1, 1'b0, LSU_WIDTH_HALF, 32'h2);
        check("lh_2", load_data, 32'hFFFF89AB);
        drive(1'b0, 1'b1, 1'b1, LSU_WIDTH_HALF, 32'h2);
        check("lhu_2", load_data, 32'h000089AB);
        drive(1'b0, 1'b1, 1'b0, LSU_WIDTH_WORD, 32'h0);
        check("lw_0", load_data, 32'h89AB67EF);
        drive(1'b0, 1'b1, 1'b0, lsu_width_e'(2'b11), 32'h0);
        check("l_illegal", load_data, 32'h89AB67EF);

        drive(1'b1, 1'b0, 1'b0, LSU_WIDTH_BYTE, 32'h2);
        check("sb_we", {28'h0, we}, 32'h4);
        check("sb_wdata", wdata, 32'h78787878);
        drive(1'b1, 1'b0, 1'b0, LSU_WIDTH_HALF, 32'h2);
        check("sh_we", {28'h0, we}, 32'hC);
        check("sh_wdata", wdata, 32'h56785678);
        drive(1'b1, 1'b0, 1'b0, LSU_WIDTH_WORD, 32'h0);
        check("sw_we", {28'h0, we}, 32'hF);
        check("sw_wdata", wdata, 32'h12345678);
        check("sw_addr", daddr, 32'h0);
        drive(1'b0, 1'b0, 1'b0, LSU_WIDTH_BYTE, 32'h3);
        check("nost_we", {28'h0, we}, 32'h0);
        check("nost_addr", daddr, 32'h0);
        check("nost_wdata", wdata, 32'h78787878);
        drive(1'b1, 1'b0, 1'b0, LSU_WIDTH_BYTE, 32'h1237);
        check("sb_hi_we", {28'h0, we}, 32'h8);
        check("sb_hi_addr", daddr, 32'h1234);

`ifdef PANDA_LSU_MISALIGN_CHECK_EN
        drive(1'b1, 1'b0, 1'b0, LSU_WIDTH_HALF, 32'h101);
        check("mis_sh_flag", {31'h0, misaligned}, 32'h1);
        check("mis_sh_we", {28'h0, we}, 32'h0);
        check("mis_pre_valid", {31'h0, err_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("mis_valid", {31'h0, err_valid}, 32'h1);
        check("mis_addr", err_addr, 32'h101);
        drive(1'b0, 1'b1, 1'b0, LSU_WIDTH_WORD, 32'h202);
        check("mis_lw_flag", {31'h0, misaligned}, 32'h1);
        @(posedge clk);
        #1;
        check("sticky_addr", err_addr, 32'h101);
        check("sticky_valid", {31'h0, err_valid}, 32'h1);
        drive(1'b0, 1'b1, 1'b0, LSU_WIDTH_HALF, 32'h102);
        check("aligned_lh_flag", {31'h0, misaligned}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, LSU_WIDTH_WORD, 32'h202);
        check("idle_flag", {31'h0, misaligned}, 32'h0);
        err_clear = 1'b1;
        drive(1'b0, 1'b1, 1'b0, LSU_WIDTH_HALF, 32'h103);
        @(posedge clk);
        #1;
        check("clr_prio_valid", {31'h0, err_valid}, 32'h0);
        err_clear = 1'b0;
        @(posedge clk);
        #1;
        check("recap_valid", {31'h0, err_valid}, 32'h1);
        check("recap_addr", err_addr, 32'h103);
        drive(1'b1, 1'b0, 1'b0, LSU_WIDTH_WORD, 32'h40);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, err_valid}, 32'h0);
        check("arst_addr", err_addr, 32'h0);
        check("arst_we", {28'h0, we}, 32'hF);
        check("arst_daddr", daddr, 32'h40);
`else
        drive(1'b1, 1'b0, 1'b0, LSU_WIDTH_HALF, 32'h101);
        check("nochk_flag", {31'h0, misaligned}, 32'h0);
        check("nochk_we", {28'h0, we}, 32'h3);
        check("nochk_wdata", wdata, 32'h56785678);
        @(posedge clk);
        #1;
        check("nochk_valid", {31'h0, err_valid}, 32'h0);
        check("nochk_addr", err_addr, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_load_store_unit.md
# sc_load_store_unit

Single-cycle load/store unit of the Panda RV32 core. It sits between the execute stage and the data-memory port. It turns a byte address, an access width and store data into a word-aligned memory address, a byte write-enable mask and lane-replicated write data. It also extracts and sign- or zero-extends load data from the returned memory word, and optionally detects and records misaligned accesses.

## Interface
Parameters: none. The access-width type `lsu_width_e` comes from `panda_pkg`.

- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `store_i`  in  1  current access is a store
- `load_i`  in  1  current access is a load; used only for misalignment detection
- `load_unsigned_i`  in  1  zero-extend load data (LBU/LHU)
- `width_i`  in  `lsu_width_e`  access width: BYTE, HALF or WORD
- `addr_i`  in  32  byte address
- `store_data_i`  in  32  store data, right-aligned
- `load_data_o`  out  32  extended load result
- `data_rdata_i`  in  32  memory read word
- `data_wdata_o`  out  32  memory write word
- `data_addr_o`  out  32  word-aligned memory address
- `data_we_o`  out  4  byte write enables; bit n enables byte lane n
- `err_clear_i`  in  1  clears the recorded misalignment error
- `misaligned_o`  out  1  the current access is misaligned (combinational)
- `err_valid_o`  out  1  a misaligned access has been recorded (registered, sticky)
- `err_addr_o`  out  32  address of the first recorded misaligned access (registered)

## Operation
- `off = addr_i[1:0]`.
- `data_addr_o = {addr_i[31:2], 2'b00}` at all times.
- Store path, active only when `store_i = 1`; otherwise `data_we_o = 4'b0000`:
  - BYTE: `we = 4'b0001 << off`; wdata = the low byte of `store_data_i` replicated 4×.
  - HALF: `we = 4'b0011 << {off[1],1'b0}`; wdata = the low halfword replicated 2×.
  - WORD: `we = 4'b1111`; wdata = `store_data_i`.
- `data_wdata_o` follows the same replication rule even when `store_i = 0`.
- Load path, always computed and independent of `store_i`:
  - BYTE: selects byte lane `off`.
  - HALF: selects halfword lane `off[1]`; `addr_i[0]` is ignored.
  - WORD: the whole word; `off` is ignored.
  - The selected field is sign-extended when `load_unsigned_i = 0` and zero-extended when it is 1. WORD is never extended.
- A `width_i` encoding of 2'b11 (illegal) behaves as WORD.
- Misalignment: `(load_i | store_i)` together with either HALF and `addr_i[0] = 1`, or WORD and `off != 0`.

## Timing
- The whole datapath is combinational, with zero-cycle latency from any input to `data_*_o`, `load_data_o` and `misaligned_o`.
- On each rising edge of `clk_i`:
  - If `err_clear_i = 1`: `err_valid_o` is cleared. Clear has priority over a simultaneous misaligned access.
  - Otherwise, if `misaligned_o = 1` and `err_valid_o = 0`: `err_valid_o` is set to 1 and `err_addr_o` captures `addr_i`.
  - Later misaligned accesses do not overwrite `err_addr_o` until a clear.
- Reset values: `err_valid_o = 0`, `err_addr_o = 0`. Reset asserted mid-operation clears both immediately and does not affect the combinational outputs.

## Configuration
- `PANDA_LSU_MISALIGN_CHECK_EN` defined:
  - misalignment detection and the error registers are implemented;
  - a misaligned store forces `data_we_o = 4'b0000`.
- Not defined:
  - `misaligned_o`, `err_valid_o` and `err_addr_o` are tied to 0;
  - accesses use the lane rules above with no write suppression;
  - `load_i`, `err_clear_i`, `clk_i` and `rst_ni` are unused.

## Structure
- `panda_pkg` holds `lsu_width_e`: 2-bit, `LSU_WIDTH_BYTE = 0`, `LSU_WIDTH_HALF = 1`, `LSU_WIDTH_WORD = 2`.
- One sub-module is natural: `panda_sc_lsu_load_extend`, covering lane select and extension from `data_rdata_i`, `off`, `width_i` and `load_unsigned_i`.

## Test plan
For all scenarios, `data_rdata_i = 32'h89AB67EF` and `store_data_i = 32'h12345678` unless stated otherwise.

- Signed byte loads at addresses 0–3 → `FFFFFFEF`, `00000067`, `FFFFFFAB`, `FFFFFF89`. With `load_unsigned_i = 1` → `000000EF`, `00000067`, `000000AB`, `00000089`.
- Halfword loads:
  - address 0 → `000067EF`;
  - address 2, signed → `FFFF89AB`;
  - address 2, unsigned → `000089AB`;
  - word load at address 0 → `89AB67EF`.
- Stores:
  - byte at address 2 → `we = 0100`, `wdata = 78787878`;
  - halfword at address 2 → `we = 1100`, `wdata = 56785678`;
  - word at address 0 → `we = 1111`, `wdata = 12345678`, `data_addr_o = 0`;
  - address 3 with `store_i = 0` → `we = 0000`, `data_addr_o = 0`.
- With the macro defined:
  - halfword store to `0x101` → `misaligned_o = 1`, `we = 0000`;
  - after the next clock edge, `err_valid_o = 1` and `err_addr_o = 0x101`;
  - a word load at `0x202` leaves `err_addr_o` at `0x101`.
- Asserting `err_clear_i` together with a misaligned access → `err_valid_o = 0` after the edge. Asserting `rst_ni` low mid-test → `err_valid_o` and `err_addr_o` are 0 immediately, with no clock edge required.
